impulse_capture: RTL
====================

Name: impulse_capture

Overview:
- Measures the room impulse response that the convolution stage later consumes.
- On a start request it emits a click through the speaker path, then counts audio samples until the microphone sees the click arrive; that count is the acoustic delay.
- It then writes the next impulse_length microphone samples into the impulse BRAM.
- Outputs feed the convolver directly: delay_length, impulse_in_memory_complete, and the BRAM write port.

Parameters:
- impulse_length, 48000, number of samples recorded into impulse memory (addresses 0..impulse_length-1).
- CLICK_LEN, 8, number of sample periods the click is driven.
- CLICK_AMPLITUDE, 16'sd24000, signed click sample value.
- MAX_DELAY, 4800, sample count in LISTEN after which capture aborts.

Ports:
- audio_clk  in  1  system audio clock.
- rst_n_in  in  1  asynchronous active-low reset.
- audio_trigger  in  1  one-cycle sample strobe.
- audio_in  in  16 signed  microphone sample, valid when audio_trigger=1.
- start_in  in  1  one-cycle request to begin a measurement.
- threshold_in  in  16  unsigned onset threshold on |audio_in|.
- click_out  out  16 signed  speaker sample (click or 0).
- write_addr  out  16  impulse BRAM address.
- write_data  out  16 signed  impulse BRAM data.
- write_enable  out  1  impulse BRAM write strobe.
- delay_length  out  16  measured delay in samples, always >=1.
- impulse_in_memory_complete  out  1  impulse memory valid.
- busy  out  1  high in EMIT/LISTEN/RECORD.
- timeout_error  out  1  last measurement aborted.

Behaviour:
- Decided interface: one clock (audio_clk); reset rst_n_in is asynchronous, active-low.
- Reset values:
  - All outputs 0; state IDLE; counters 0.
  - Reset mid-operation aborts immediately. BRAM contents are untouched, but complete=0.
- All outputs are registered. Sample-domain events occur only on audio_trigger cycles.
- States: IDLE, EMIT, LISTEN, RECORD, DONE.
- IDLE:
  - start_in=1 -> EMIT.
  - On entry: clear timeout_error, complete, delay counter (sample_cnt=0) and addr counter.
- EMIT:
  - On each strobe: click_out<=CLICK_AMPLITUDE, run onset check, sample_cnt++.
  - After CLICK_LEN strobes, click_out<=0 and -> LISTEN.
  - Onset detected during EMIT goes directly to RECORD; click_out is forced to 0 the same cycle.
- Onset check:
  - abs computed 17 bits wide, so -32768 -> 32768. Onset when abs(audio_in) >= threshold_in.
  - sample_cnt counts strobes since the first click strobe; the first click strobe is count 0.
  - On onset: delay_length<=max(sample_cnt,1) and -> RECORD. The onset sample is itself written at address 0.
- LISTEN:
  - Each strobe runs the onset check, then sample_cnt++.
  - If sample_cnt reaches MAX_DELAY without onset: timeout_error<=1, delay_length unchanged, -> IDLE.
- RECORD:
  - For each strobe (including the onset strobe), the next cycle drives write_enable=1 for exactly one cycle, with write_addr=addr and write_data=audio_in. Then addr++.
  - After the write with addr=impulse_length-1: -> DONE.
  - impulse_in_memory_complete rises the cycle after that final write pulse.
- DONE:
  - complete held high, busy=0.
  - start_in clears complete and restarts via EMIT (same entry clears as IDLE).
- start_in while busy is ignored.
- A strobe and start_in in the same IDLE cycle: start takes effect, and that strobe is not counted.
- write_enable is 0 outside RECORD. write_addr and write_data hold their last values when write_enable=0.
- Counters are 16-bit. sample_cnt saturates at MAX_DELAY; addr never exceeds impulse_length-1.

Test Plan:
- Reset then idle strobes -> click_out, write_enable, delay_length and complete all 0; busy=0.
- start_in, threshold_in=1000; mic returns 0 except audio_in=-5000 on strobe 37 -> click_out=24000 on strobes 0..7; delay_length=37; first write addr0=-5000.
- impulse_length=16 override, onset at strobe 20 -> 16 single-cycle write pulses, addrs 0..15, data matching the mic samples. complete rises the cycle after the 16th pulse; busy falls.
- Onset at strobe 0 (loopback: audio_in=click) -> delay_length=1; click_out drops to 0 after one strobe.
- No onset, MAX_DELAY=100 -> timeout_error=1 after 100 strobes; no write pulses; complete=0; state IDLE.
- Assert rst_n_in low at RECORD addr 7 -> outputs 0 asynchronously. A new start after release re-measures correctly, and start_in during busy has no effect.

Source files
------------

// File: rtl/impulse_capture.sv
`default_nettype none
// ============================================================================
// impulse_capture : emits a click, measures acoustic delay, records impulse
// Rev 1.0
// ============================================================================
module impulse_capture #(
  parameter int unsigned        impulse_length  = 48000,
  parameter int unsigned        CLICK_LEN       = 8,
  parameter logic signed [15:0] CLICK_AMPLITUDE = 16'sd24000,
  parameter int unsigned        MAX_DELAY       = 4800
) (
  input  logic               audio_clk,
  input  logic               rst_n_in,
  input  logic               audio_trigger,
  input  logic signed [15:0] audio_in,
  input  logic               start_in,
  input  logic        [15:0] threshold_in,
  output logic signed [15:0] click_out,
  output logic        [15:0] write_addr,
  output logic signed [15:0] write_data,
  output logic               write_enable,
  output logic        [15:0] delay_length,
  output logic               impulse_in_memory_complete,
  output logic               busy,
  output logic               timeout_error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EMIT   = 3'd1,
    S_LISTEN = 3'd2,
    S_RECORD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] c_last_addr = 16'(impulse_length - 1);
  localparam logic [15:0] c_click_len = 16'(CLICK_LEN);
  localparam logic [15:0] c_max_delay = 16'(MAX_DELAY);

  state_t             r_state;
  state_t             w_state_nxt;
  logic        [15:0] r_sample_cnt;
  logic        [15:0] w_sample_cnt_nxt;
  logic        [15:0] r_addr;
  logic        [15:0] w_addr_nxt;
  logic signed [15:0] w_click_nxt;
  logic        [15:0] w_waddr_nxt;
  logic signed [15:0] w_wdata_nxt;
  logic               w_we_nxt;
  logic        [15:0] w_delay_nxt;
  logic               w_complete_nxt;
  logic               w_timeout_nxt;
  logic               w_busy_nxt;
  logic               w_write;
  logic        [16:0] w_abs;
  logic               w_onset;
  logic        [15:0] w_cnt_inc;

  // 17-bit magnitude so that -32768 compares as 32768
  always_comb begin
    w_abs     = audio_in[15] ? (17'd0 - {audio_in[15], audio_in}) : {1'b0, audio_in};
    w_onset   = (w_abs >= {1'b0, threshold_in});
    w_cnt_inc = (r_sample_cnt >= c_max_delay) ? c_max_delay : (r_sample_cnt + 16'd1);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sample_cnt_nxt = r_sample_cnt;
    w_addr_nxt       = r_addr;
    w_click_nxt      = click_out;
    w_waddr_nxt      = write_addr;
    w_wdata_nxt      = write_data;
    w_we_nxt         = 1'b0;
    w_delay_nxt      = delay_length;
    w_complete_nxt   = impulse_in_memory_complete;
    w_timeout_nxt    = timeout_error;
    w_write          = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) begin
          w_complete_nxt = 1'b1;
        end
        if (start_in) begin
          w_state_nxt      = S_EMIT;
          w_sample_cnt_nxt = 16'd0;
          w_addr_nxt       = 16'd0;
          w_complete_nxt   = 1'b0;
          w_timeout_nxt    = 1'b0;
        end
      end

      S_EMIT: begin
        if (audio_trigger) begin
          if (w_onset) begin
            w_click_nxt = 16'sd0;
            w_delay_nxt = (r_sample_cnt == 16'd0) ? 16'd1 : r_sample_cnt;
            w_write     = 1'b1;
            w_state_nxt = S_RECORD;
          end else begin
            w_click_nxt      = CLICK_AMPLITUDE;
            w_sample_cnt_nxt = w_cnt_inc;
            if ((r_sample_cnt + 16'd1) >= c_click_len) begin
              w_state_nxt = S_LISTEN;
            end
          end
        end
      end

      S_LISTEN: begin
        if (audio_trigger) begin
          // the last click sample is held for a full sample period, released here
          w_click_nxt = 16'sd0;
          if (w_onset) begin
            w_delay_nxt = (r_sample_cnt == 16'd0) ? 16'd1 : r_sample_cnt;
            w_write     = 1'b1;
            w_state_nxt = S_RECORD;
          end else begin
            w_sample_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= c_max_delay) begin
              w_timeout_nxt = 1'b1;
              w_state_nxt   = S_IDLE;
            end
          end
        end
      end

      S_RECORD: begin
        if (audio_trigger) begin
          w_write = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_write) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = r_addr;
      w_wdata_nxt = audio_in;
      if (r_addr == c_last_addr) begin
        w_state_nxt = S_DONE;
      end else begin
        w_addr_nxt = r_addr + 16'd1;
      end
    end

    w_busy_nxt = (w_state_nxt == S_EMIT) || (w_state_nxt == S_LISTEN) ||
                 (w_state_nxt == S_RECORD);
  end

  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state                    <= S_IDLE;
      r_sample_cnt               <= 16'd0;
      r_addr                     <= 16'd0;
      click_out                  <= 16'sd0;
      write_addr                 <= 16'd0;
      write_data                 <= 16'sd0;
      write_enable               <= 1'b0;
      delay_length               <= 16'd0;
      impulse_in_memory_complete <= 1'b0;
      busy                       <= 1'b0;
      timeout_error              <= 1'b0;
    end else begin
      r_state                    <= w_state_nxt;
      r_sample_cnt               <= w_sample_cnt_nxt;
      r_addr                     <= w_addr_nxt;
      click_out                  <= w_click_nxt;
      write_addr                 <= w_waddr_nxt;
      write_data                 <= w_wdata_nxt;
      write_enable               <= w_we_nxt;
      delay_length               <= w_delay_nxt;
      impulse_in_memory_complete <= w_complete_nxt;
      busy                       <= w_busy_nxt;
      timeout_error              <= w_timeout_nxt;
    end
  end

endmodule
`default_nettype wire
